// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the MEM-stage load/store path.
// A request (store or load) is accepted in IDLE, held for WAIT_CYCLES wait
// states, then answered with a one-cycle ack.
// Stores merge the enabled byte lanes into a word-organised RAM.
// Loads return the addressed byte, halfword or word, sign- or zero-extended.
// Illegal byte-enable/address/load-type combinations are answered with err=1.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous reset, active-high (control state only; RAM untouched)
//   req      request valid, sampled only while ready=1
//   we       1=store, 0=load
//   addr     byte address; word index = addr[ADDR_WIDTH+1:2], upper bits alias
//   be       byte-enable, lane 0 = bits [7:0]
//   wdata    store data, right-justified
//   ld_type  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU
//   ready    high in IDLE only
//   ack      one-cycle response pulse
//   err      request rejected, valid with ack
//   rdata    load result, valid with ack; 0 for stores and errors; held otherwise
module dmem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [3:0]  be,
  input  logic [31:0] wdata,
  input  logic [2:0]  ld_type,
  output logic        ready,
  output logic        ack,
  output logic        err,
  output logic [31:0] rdata
);

  localparam logic [2:0] LD_LW  = 3'd0;
  localparam logic [2:0] LD_LH  = 3'd1;
  localparam logic [2:0] LD_LHU = 3'd2;
  localparam logic [2:0] LD_LB  = 3'd3;
  localparam logic [2:0] LD_LBU = 3'd4;

  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Legal shapes are naturally aligned byte, halfword and word accesses.
  // Loads additionally need ld_type to agree with the access width.
  function automatic logic req_legal(input logic is_store, input logic [1:0] off,
                                     input logic [3:0] lanes, input logic [2:0] lt);
    logic       shape_ok;
    logic [1:0] width;  // 0 byte, 1 half, 2 word
    shape_ok = 1'b0;
    width    = 2'd0;
    case ({lanes, off})
      {4'hf, 2'd0}: begin shape_ok = 1'b1; width = 2'd2; end
      {4'h3, 2'd0},
      {4'hc, 2'd2}: begin shape_ok = 1'b1; width = 2'd1; end
      {4'h1, 2'd0},
      {4'h2, 2'd1},
      {4'h4, 2'd2},
      {4'h8, 2'd3}: begin shape_ok = 1'b1; width = 2'd0; end
      default:      begin shape_ok = 1'b0; width = 2'd0; end
    endcase
    if (is_store) return shape_ok;
    case (lt)
      LD_LW:          return shape_ok && (width == 2'd2);
      LD_LH, LD_LHU:  return shape_ok && (width == 2'd1);
      LD_LB, LD_LBU:  return shape_ok && (width == 2'd0);
      default:        return 1'b0;
    endcase
  endfunction

  // Replicate the right-justified store data across the word so that every
  // enabled lane sees its byte; the byte-enable then selects what is written.
  function automatic logic [31:0] store_lanes(input logic [3:0] lanes, input logic [31:0] d);
    case (lanes)
      4'hf:       return d;
      4'h3, 4'hc: return {2{d[15:0]}};
      default:    return {4{d[7:0]}};
    endcase
  endfunction

  // Shift the addressed lane(s) down to bit 0, then extend per load type.
  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] off,
                                              input logic [2:0] lt);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (lt)
      LD_LH:   return {{16{sh[15]}}, sh[15:0]};
      LD_LHU:  return {16'h0000, sh[15:0]};
      LD_LB:   return {{24{sh[7]}}, sh[7:0]};
      LD_LBU:  return {24'h000000, sh[7:0]};
      default: return sh;
    endcase
  endfunction

  state_t                  state;
  logic [3:0]              cnt;
  logic                    we_p0;
  logic [1:0]              off_p0;
  logic [ADDR_WIDTH-1:0]   idx_p0;
  logic [3:0]              be_p0;
  logic [31:0]             wdata_p0;
  logic [2:0]              lt_p0;
  logic                    err_p0;
  logic [31:0]             wlanes_p0;
  logic [31:0]             mem [2**ADDR_WIDTH];

  // Address bits above the RAM index alias onto the same words.
  logic unused_addr;
  assign unused_addr = ^addr[31:ADDR_WIDTH+2];

  // ---- p0: request capture at acceptance ----
  always_ff @(posedge clk) begin
    if (state == IDLE && req) begin
      we_p0    <= we;
      off_p0   <= addr[1:0];
      idx_p0   <= addr[ADDR_WIDTH+1:2];
      be_p0    <= be;
      wdata_p0 <= wdata;
      lt_p0    <= ld_type;
      err_p0   <= !req_legal(we, addr[1:0], be, ld_type);
    end
  end

  assign wlanes_p0 = store_lanes(be_p0, wdata_p0);

  // ---- RESP edge: store commit (suppressed by reset or error) ----
  always_ff @(posedge clk) begin
    if (!rst && state == RESP && we_p0 && !err_p0) begin
      for (int i = 0; i < 4; i++) begin
        if (be_p0[i]) mem[idx_p0][8*i +: 8] <= wlanes_p0[8*i +: 8];
      end
    end
  end

  // ---- control FSM with registered outputs ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
      ready <= 1'b1;
      ack   <= 1'b0;
      err   <= 1'b0;
      rdata <= 32'h0;
    end else begin
      ack <= 1'b0;
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            ready <= 1'b0;
            if (WAIT_CYCLES > 0) begin
              state <= WAIT;
              cnt   <= CNT_INIT;
            end else begin
              state <= RESP;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) state <= RESP;
          else             cnt   <= cnt - 4'd1;
        end
        RESP: begin
          ack   <= 1'b1;
          err   <= err_p0;
          rdata <= (err_p0 || we_p0) ? 32'h0 : load_extend(mem[idx_p0], off_p0, lt_p0);
          ready <= 1'b1;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder. Two instances (WAIT_CYCLES=1 and 3) are driven
// independently. Expected results come from a byte-addressed memory model that
// applies the access rules directly (natural alignment, width from popcount).
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst_s, req_s, we_s, ready_s, ack_s, err_s;
  logic [31:0] addr_s [2];
  logic [31:0] wdata_s [2];
  logic [31:0] rdata_s [2];
  logic [3:0]  be_s [2];
  logic [2:0]  lt_s [2];

  int checks = 0;
  int errors = 0;

  // Byte model of the low 64 bytes of each instance (the region tests use).
  logic [7:0] mb [2][64];
  bit         kn [2][64];

  dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(1)) dut_w1 (
    .clk(clk), .rst(rst_s[0]), .req(req_s[0]), .we(we_s[0]), .addr(addr_s[0]),
    .be(be_s[0]), .wdata(wdata_s[0]), .ld_type(lt_s[0]), .ready(ready_s[0]),
    .ack(ack_s[0]), .err(err_s[0]), .rdata(rdata_s[0]));

  dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(3)) dut_w3 (
    .clk(clk), .rst(rst_s[1]), .req(req_s[1]), .we(we_s[1]), .addr(addr_s[1]),
    .be(be_s[1]), .wdata(wdata_s[1]), .ld_type(lt_s[1]), .ready(ready_s[1]),
    .ack(ack_s[1]), .err(err_s[1]), .rdata(rdata_s[1]));

  function automatic int wc(input int u);
    return (u == 0) ? 1 : 3;
  endfunction

  // One transaction: model, drive, wait for ack (bounded), compare.
  task automatic txn(input int u, input logic w, input logic [31:0] a, input logic [3:0] b,
                     input logic [31:0] wd, input logic [2:0] lt, input bit b2b, input bit hold,
                     input bit use_k, input logic k_err, input logic [31:0] k_rd);
    int sz, lsz, base, lat;
    logic legal, rd_known;
    logic [31:0] v, exp_rd;
    sz = $countones(b);
    base = int'(a[5:0]);
    legal = 1'b0;
    if (sz == 1 || sz == 2 || sz == 4)
      legal = (int'(a[1:0]) % sz == 0) && (b == 4'(((1 << sz) - 1) << a[1:0]));
    if (!w) begin
      case (lt)
        3'd0:       lsz = 4;
        3'd1, 3'd2: lsz = 2;
        3'd3, 3'd4: lsz = 1;
        default:    lsz = 0;
      endcase
      legal = legal && (lsz == sz);
    end
    exp_rd = 32'h0;
    rd_known = 1'b1;
    if (legal && !w) begin
      v = 32'h0;
      for (int k = 0; k < sz; k++) begin
        if (!kn[u][base+k]) rd_known = 1'b0;
        v = v | (32'(mb[u][base+k]) << (8*k));
      end
      if (lt == 3'd1 && v[15]) v = v | 32'hFFFF0000;
      if (lt == 3'd3 && v[7])  v = v | 32'hFFFFFF00;
      exp_rd = v;
    end

    if (!b2b) @(negedge clk);
    checks++;
    if (ready_s[u] !== 1'b1) begin
      errors++;
      $display("FAIL ready_idle u%0d: got %b want 1", u, ready_s[u]);
    end
    req_s[u] = 1'b1; we_s[u] = w; addr_s[u] = a; be_s[u] = b; wdata_s[u] = wd; lt_s[u] = lt;
    @(posedge clk);
    @(negedge clk);
    if (hold) begin
      // Keep req high with different contents; must be ignored while busy.
      addr_s[u] = a ^ 32'h4; wdata_s[u] = ~wd; we_s[u] = ~w;
    end else begin
      req_s[u] = 1'b0;
    end
    lat = 0;
    while (ack_s[u] !== 1'b1 && lat < 20) begin
      checks++;
      if (ready_s[u] !== 1'b0) begin
        errors++;
        $display("FAIL ready_busy u%0d: got %b want 0", u, ready_s[u]);
      end
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    req_s[u] = 1'b0;
    if (legal && w)
      for (int k = 0; k < sz; k++) begin
        mb[u][base+k] = wd[8*k +: 8];
        kn[u][base+k] = 1'b1;
      end
    checks++;
    if (lat != wc(u) + 1) begin
      errors++;
      $display("FAIL latency u%0d addr %h: got %0d want %0d", u, a, lat, wc(u) + 1);
    end
    checks++;
    if (err_s[u] !== !legal) begin
      errors++;
      $display("FAIL err u%0d we %b addr %h be %h lt %0d: got %b want %b", u, w, a, b, lt, err_s[u], !legal);
    end
    if (rd_known) begin
      checks++;
      if (rdata_s[u] !== exp_rd) begin
        errors++;
        $display("FAIL rdata u%0d we %b addr %h be %h lt %0d: got %h want %h", u, w, a, b, lt, rdata_s[u], exp_rd);
      end
    end
    checks++;
    if (ready_s[u] !== 1'b1) begin
      errors++;
      $display("FAIL ready_at_ack u%0d: got %b want 1", u, ready_s[u]);
    end
    if (use_k) begin
      checks++;
      if (err_s[u] !== k_err || rdata_s[u] !== k_rd) begin
        errors++;
        $display("FAIL plan_vector u%0d addr %h: got err %b rdata %h want err %b rdata %h",
                 u, a, err_s[u], rdata_s[u], k_err, k_rd);
      end
    end
  endtask

  task automatic test_reset();
    rst_s = 2'b11; req_s = 2'b00; we_s = 2'b00;
    for (int u = 0; u < 2; u++) begin
      addr_s[u] = 32'h0; be_s[u] = 4'h0; wdata_s[u] = 32'h0; lt_s[u] = 3'd0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_s = 2'b00;
    for (int u = 0; u < 2; u++) begin
      checks++;
      if (ready_s[u] !== 1'b1 || ack_s[u] !== 1'b0 || err_s[u] !== 1'b0 || rdata_s[u] !== 32'h0) begin
        errors++;
        $display("FAIL reset_values u%0d: got ready %b ack %b err %b rdata %h want 1 0 0 00000000",
                 u, ready_s[u], ack_s[u], err_s[u], rdata_s[u]);
      end
    end
  endtask

  task automatic test_directed();
    txn(0, 1, 32'h10, 4'hf, 32'h11223344, 3'd0, 0, 0, 1, 1'b0, 32'h0);
    txn(0, 0, 32'h10, 4'hf, 32'h0, 3'd0, 0, 0, 1, 1'b0, 32'h11223344);
    txn(0, 1, 32'h12, 4'h4, 32'h000000AB, 3'd5, 0, 0, 1, 1'b0, 32'h0);
    txn(0, 0, 32'h10, 4'hf, 32'h0, 3'd0, 0, 0, 1, 1'b0, 32'h11AB3344);
    txn(0, 0, 32'h12, 4'h4, 32'h0, 3'd3, 0, 0, 1, 1'b0, 32'hFFFFFFAB);
    txn(0, 0, 32'h12, 4'h4, 32'h0, 3'd4, 0, 0, 1, 1'b0, 32'h000000AB);
    txn(0, 1, 32'h10, 4'h3, 32'h00008001, 3'd0, 0, 0, 1, 1'b0, 32'h0);
    txn(0, 0, 32'h10, 4'h3, 32'h0, 3'd1, 0, 0, 1, 1'b0, 32'hFFFF8001);
    txn(0, 0, 32'h10, 4'h3, 32'h0, 3'd2, 0, 0, 1, 1'b0, 32'h00008001);
    txn(0, 0, 32'h12, 4'hc, 32'h0, 3'd1, 0, 0, 1, 1'b0, 32'h000011AB);
    txn(0, 1, 32'h10, 4'h2, 32'hFFFFFFFF, 3'd0, 0, 0, 1, 1'b1, 32'h0);
    txn(0, 0, 32'h10, 4'hf, 32'h0, 3'd0, 0, 0, 1, 1'b0, 32'h11AB8001);
    txn(0, 0, 32'h10, 4'h3, 32'h0, 3'd0, 0, 0, 1, 1'b1, 32'h0);
    txn(0, 0, 32'h10, 4'h0, 32'h0, 3'd3, 0, 0, 1, 1'b1, 32'h0);
    txn(0, 0, 32'h10, 4'h1, 32'h0, 3'd7, 0, 0, 1, 1'b1, 32'h0);
    // Aliased address: upper bits are ignored.
    txn(0, 0, 32'hABC00010, 4'hf, 32'h0, 3'd0, 0, 0, 1, 1'b0, 32'h11AB8001);
  endtask

  task automatic test_hold_and_rdata();
    logic [31:0] held;
    txn(0, 0, 32'h10, 4'hf, 32'h0, 3'd0, 0, 1, 1, 1'b0, 32'h11AB8001);
    held = 32'h11AB8001;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (ack_s[0] !== 1'b0 || rdata_s[0] !== held) begin
        errors++;
        $display("FAIL idle_after_ack cyc %0d: got ack %b rdata %h want ack 0 rdata %h", i, ack_s[0], rdata_s[0], held);
      end
    end
  endtask

  task automatic test_back_to_back();
    txn(0, 1, 32'h18, 4'hf, 32'hCAFEF00D, 3'd0, 0, 0, 1, 1'b0, 32'h0);
    txn(0, 0, 32'h18, 4'hf, 32'h0, 3'd0, 1, 0, 1, 1'b0, 32'hCAFEF00D);
    txn(0, 0, 32'h1B, 4'h8, 32'h0, 3'd3, 1, 0, 1, 1'b0, 32'hFFFFFFCA);
    txn(1, 1, 32'h24, 4'hf, 32'h01020304, 3'd0, 0, 0, 1, 1'b0, 32'h0);
    txn(1, 0, 32'h26, 4'hc, 32'h0, 3'd2, 1, 0, 1, 1'b0, 32'h00000102);
  endtask

  task automatic test_reset_abort();
    txn(1, 1, 32'h20, 4'hf, 32'h0BADF00D, 3'd0, 0, 0, 1, 1'b0, 32'h0);
    @(negedge clk);
    req_s[1] = 1'b1; we_s[1] = 1'b1; addr_s[1] = 32'h20; be_s[1] = 4'hf;
    wdata_s[1] = 32'hDEADBEEF; lt_s[1] = 3'd0;
    @(posedge clk);
    @(negedge clk);
    req_s[1] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_s[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_s[1] = 1'b0;
    checks++;
    if (ready_s[1] !== 1'b1 || ack_s[1] !== 1'b0 || rdata_s[1] !== 32'h0) begin
      errors++;
      $display("FAIL abort_state: got ready %b ack %b rdata %h want 1 0 00000000", ready_s[1], ack_s[1], rdata_s[1]);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (ack_s[1] !== 1'b0) begin
        errors++;
        $display("FAIL abort_no_ack cyc %0d: got %b want 0", i, ack_s[1]);
      end
    end
    txn(1, 0, 32'h20, 4'hf, 32'h0, 3'd0, 0, 0, 1, 1'b0, 32'h0BADF00D);
  endtask

  task automatic test_random(input int u, input int n);
    logic [31:0] a, wd;
    logic [3:0]  b;
    logic [2:0]  lt;
    logic        w;
    int sz, off;
    for (int i = 0; i < 16; i++) begin
      a = $urandom;
      a[11:0] = 12'(i * 4);
      txn(u, 1, a, 4'hf, $urandom, 3'($urandom_range(0, 7)), 0, 0, 0, 1'b0, 32'h0);
    end
    for (int i = 0; i < n; i++) begin
      a = $urandom;
      a[11:6] = 6'd0;
      w = 1'($urandom_range(0, 1));
      wd = $urandom;
      if ($urandom_range(0, 9) < 2) begin
        b = 4'($urandom);
        lt = 3'($urandom_range(0, 7));
      end else begin
        case ($urandom_range(0, 2))
          0: sz = 1;
          1: sz = 2;
          default: sz = 4;
        endcase
        off = sz * $urandom_range(0, 4 / sz - 1);
        a[1:0] = 2'(off);
        b = 4'(((1 << sz) - 1) << off);
        if (sz == 4)      lt = 3'd0;
        else if (sz == 2) lt = 3'($urandom_range(1, 2));
        else              lt = 3'($urandom_range(3, 4));
        if ($urandom_range(0, 9) == 0) lt = 3'($urandom_range(0, 7));
      end
      txn(u, w, a, b, wd, lt, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), 0, 1'b0, 32'h0);
    end
  endtask

  initial begin
    for (int u = 0; u < 2; u++)
      for (int k = 0; k < 64; k++) begin
        mb[u][k] = 8'h00;
        kn[u][k] = 1'b0;
      end
    test_reset();
    test_directed();
    test_hold_and_rdata();
    test_back_to_back();
    test_reset_abort();
    test_random(0, 150);
    test_random(1, 100);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
